// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states and ALU encodings.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b011111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BLEEX   = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: fixed add/subtract for address and branch work, funct field for R-type.
module multicycle_controller_aludec
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller: Moore FSM plus the combinational branch and store-width terms.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       sign,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       memwrite,
  output logic       memwidth,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t     state_q, state_d, cur;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_SB: state_d = MEMADR;
          OP_RTYPE:            state_d = RTYPEEX;
          OP_BEQ:              state_d = BEQEX;
          OP_BLE:              state_d = BLEEX;
          OP_ADDI:             state_d = ADDIEX;
          OP_J:                state_d = JEX;
          default:             state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // A reset cycle presents the FETCH decode with every write enable masked off.
  always_comb begin
    cur      = reset ? FETCH : state_q;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcen     = 1'b0;
    memwrite = 1'b0;
    memwidth = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    case (cur)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcen    = 1'b1;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        memwidth = (op == OP_SB);
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX, BLEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        pcen    = (cur == BEQEX) ? zero : (zero | sign);
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      pcen     = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  multicycle_controller_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with an instruction-level reference model.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, sign;
  logic       iord, irwrite, pcen, memwrite, memwidth, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .sign(sign),
    .iord(iord), .irwrite(irwrite), .pcen(pcen), .memwrite(memwrite), .memwidth(memwidth),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  // [15]iord [14]irwrite [13]pcen [12]memwrite [11]memwidth [10]regwrite
  // [9]regdst [8]memtoreg [7]alusrca [6:5]alusrcb [4:3]pcsrc [2:0]alucontrol
  logic [15:0] outv;
  assign outv = {iord, irwrite, pcen, memwrite, memwidth, regwrite, regdst, memtoreg,
                 alusrca, alusrcb, pcsrc, alucontrol};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int path_len(input logic [5:0] o);
    case (o)
      OP_LW:                             return 5;
      OP_SW, OP_SB, OP_RTYPE, OP_ADDI:   return 4;
      OP_BEQ, OP_BLE, OP_J:              return 3;
      default:                           return 2;
    endcase
  endfunction

  function automatic state_t path_state(input logic [5:0] o, input int k);
    if (k == 0) return FETCH;
    if (k == 1) return DECODE;
    case (o)
      OP_LW:        return (k == 2) ? MEMADR : (k == 3) ? MEMRD : MEMWB;
      OP_SW, OP_SB: return (k == 2) ? MEMADR : MEMWR;
      OP_RTYPE:     return (k == 2) ? RTYPEEX : RTYPEWB;
      OP_ADDI:      return (k == 2) ? ADDIEX : ADDIWB;
      OP_BEQ:       return BEQEX;
      OP_BLE:       return BLEEX;
      OP_J:         return JEX;
      default:      return FETCH;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [15:0] expect_out(input state_t st, input logic [5:0] o,
      input logic [5:0] f, input logic z, input logic s, input logic r);
    logic [15:0] v;
    v = 16'h0;
    v[2:0] = 3'b010;
    if (r) begin
      v[6:5] = 2'b01;
      return v;
    end
    case (st)
      FETCH:   begin v[14] = 1'b1; v[13] = 1'b1; v[6:5] = 2'b01; end
      DECODE:  v[6:5] = 2'b11;
      MEMADR, ADDIEX: begin v[7] = 1'b1; v[6:5] = 2'b10; end
      MEMRD:   v[15] = 1'b1;
      MEMWB:   begin v[8] = 1'b1; v[10] = 1'b1; end
      MEMWR:   begin v[15] = 1'b1; v[12] = 1'b1; v[11] = (o == 6'b101000); end
      RTYPEEX: begin v[7] = 1'b1; v[2:0] = funct_alu(f); end
      RTYPEWB: begin v[9] = 1'b1; v[10] = 1'b1; end
      BEQEX:   begin v[7] = 1'b1; v[2:0] = 3'b110; v[4:3] = 2'b01; v[13] = z; end
      BLEEX:   begin v[7] = 1'b1; v[2:0] = 3'b110; v[4:3] = 2'b01; v[13] = z | s; end
      ADDIWB:  v[10] = 1'b1;
      JEX:     begin v[4:3] = 2'b10; v[13] = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  int   step = 0;
  logic model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      step        <= 0;
      model_valid <= 1'b1;
    end else if (model_valid) begin
      step <= (step + 1 == path_len(op)) ? 0 : step + 1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("outputs", 32'(outv),
            32'(expect_out(path_state(op, step), op, funct, zero, sign, reset)));
      if (!reset) check("state", 32'(state), 32'(path_state(op, step)));
      check("write_exclusive", 32'($countones({memwrite, regwrite, irwrite}) <= 1), 32'd1);
    end
  end

  logic [15:0] snap_out [1:8];
  logic [3:0]  snap_st  [1:8];

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic s, input int rst_at);
    op = o; funct = f; zero = z; sign = s;
    for (int c = 1; c <= path_len(o); c++) begin
      if (c == rst_at) reset = 1'b1;
      @(negedge clk);
      snap_out[c] = outv;
      snap_st[c]  = state;
      @(posedge clk);
      #1;
      if (c == rst_at) begin
        reset = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    state_t      lw_seq [5];
    logic [3:0]  ble_pcen;
    logic [5:0]  fns [5];
    logic [2:0]  fn_alu [5];

    lw_seq   = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
    ble_pcen = 4'b1110;
    fns      = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    fn_alu   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; sign = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    check("rst_pcen", 32'(pcen), 32'd0);
    check("rst_alusrcb", 32'(alusrcb), 32'd1);
    check("rst_alucontrol", 32'(alucontrol), 32'd2);
    check("rst_state", 32'(state), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(OP_LW, '0, 1'b0, 1'b0, 0);
    check("lw_fetch_pcen", 32'(snap_out[1][13]), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      check("lw_state", 32'(snap_st[c]), 32'(lw_seq[c-1]));
      check("lw_regwrite", 32'(snap_out[c][10]), 32'(c == 5));
      check("lw_memtoreg", 32'(snap_out[c][8]), 32'(c == 5));
    end

    run_instr(OP_SW, '0, 1'b0, 1'b0, 0);
    check("lw_back_to_fetch", 32'(snap_st[1]), 32'd0);
    for (int c = 1; c <= 4; c++) check("sw_memwidth", 32'(snap_out[c][11]), 32'd0);
    check("sw_memwrite", 32'(snap_out[4][12]), 32'd1);

    run_instr(OP_SB, '0, 1'b0, 1'b0, 0);
    for (int c = 1; c <= 4; c++) begin
      check("sb_memwrite", 32'(snap_out[c][12]), 32'(c == 4));
      check("sb_memwidth", 32'(snap_out[c][11]), 32'(c == 4));
    end

    for (int zs = 0; zs < 4; zs++) begin
      logic [1:0] zsv;
      zsv = 2'(zs);
      run_instr(OP_BLE, '0, zsv[1], zsv[0], 0);
      check("ble_pcen", 32'(snap_out[3][13]), 32'(ble_pcen[zs]));
    end

    run_instr(OP_BEQ, '0, 1'b0, 1'b1, 0);
    check("beq_z0s1_pcen", 32'(snap_out[3][13]), 32'd0);
    run_instr(OP_BEQ, '0, 1'b1, 1'b0, 0);
    check("beq_z1_pcen", 32'(snap_out[3][13]), 32'd1);
    check("beq_alucontrol", 32'(snap_out[3][2:0]), 32'h6);

    for (int i = 0; i < 5; i++) begin
      run_instr(OP_RTYPE, fns[i], 1'b0, 1'b0, 0);
      check("rtype_alucontrol", 32'(snap_out[3][2:0]), 32'(fn_alu[i]));
      check("rtype_regdst", 32'(snap_out[4][9]), 32'd1);
      check("rtype_regwrite", 32'(snap_out[4][10]), 32'd1);
    end

    run_instr(OP_ADDI, 6'b100010, 1'b0, 1'b0, 0);
    check("addi_regwrite", 32'(snap_out[4][10]), 32'd1);
    check("addi_alusrcb", 32'(snap_out[3][6:5]), 32'd2);

    run_instr(OP_J, '0, 1'b0, 1'b0, 0);
    check("j_pcen", 32'(snap_out[3][13]), 32'd1);
    check("j_pcsrc", 32'(snap_out[3][4:3]), 32'd2);

    run_instr(OP_SW, '0, 1'b0, 1'b0, 4);
    check("rst_in_memwr_memwrite", 32'(snap_out[4][12]), 32'd0);

    run_instr(6'b111111, '0, 1'b0, 1'b0, 0);
    check("after_reset_fetch", 32'(snap_st[1]), 32'd0);
    check("undef_decode_state", 32'(snap_st[2]), 32'd1);
    check("undef_decode_enables",
          32'({snap_out[2][14], snap_out[2][13], snap_out[2][12], snap_out[2][10]}), 32'd0);

    run_instr(OP_ADDI, '0, 1'b0, 1'b0, 0);
    check("undef_back_to_fetch", 32'(snap_st[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001: Clocking and reset SHALL be one clock and one synchronous, active-high reset.
REQ-002: clk  input  1  system clock; all state updates on its rising edge.
REQ-003: reset  input  1  synchronous active-high reset.
REQ-004: op  input  6  opcode from instruction register.
REQ-005: funct  input  6  R-type function field.
REQ-006: zero  input  1  ALU result equals zero.
REQ-007: sign  input  1  ALU result MSB; zero|sign means less-than-or-equal after subtract.
REQ-008: iord  output  1  memory address source: 0 = PC, 1 = ALUOut.
REQ-009: irwrite  output  1  instruction register load enable.
REQ-010: pcen  output  1  PC write enable.
REQ-011: memwrite  output  1  data memory write enable.
REQ-012: memwidth  output  1  store width: 0 = word, 1 = byte.
REQ-013: regwrite  output  1  register file write enable.
REQ-014: regdst  output  1  destination: 0 = rt, 1 = rd.
REQ-015: memtoreg  output  1  writeback source: 0 = ALUOut, 1 = Data register.
REQ-016: alusrca  output  1  SrcA: 0 = PC, 1 = register A.
REQ-017: alusrcb  output  2  SrcB: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
REQ-018: pcsrc  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-019: alucontrol  output  3  ALU operation (existing encoding).
REQ-020: state  output  4  current FSM state, for debug and verification.

Function
REQ-021: Opcodes: RTYPE 000000, LW 100011, SW 101011, SB 101000, BEQ 000100, BLE 011111, ADDI 001000, J 000010.
REQ-022: States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BLEEX, ADDIEX, ADDIWB, JEX.
REQ-023: Transitions:
- FETCH->DECODE.
- DECODE->MEMADR (LW/SW/SB), RTYPEEX, BEQEX, BLEEX, ADDIEX or JEX by op.
- MEMADR->MEMRD (LW) or MEMWR (SW/SB).
- MEMRD->MEMWB.
- RTYPEEX->RTYPEWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BLEEX, JEX->FETCH.
REQ-024: An unrecognised op in DECODE SHALL return to FETCH with no write enable asserted.
REQ-025: Outputs SHALL be Moore (state-only), except pcen and memwidth. Every unlisted output is 0 and alucontrol is add (010).
- FETCH: irwrite=1, alusrcb=01, pcsrc=00, pcen=1.
- DECODE: alusrcb=11.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1, memwidth=(op==SB).
- RTYPEEX: alusrca=1, alucontrol from funct.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX and BLEEX: alusrca=1, alucontrol=subtract (110), pcsrc=01.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcen=1.
REQ-026: In BEQEX, pcen SHALL equal zero. In BLEEX, pcen SHALL equal zero|sign. Both are combinational in the same cycle.
REQ-027: memwidth SHALL be 0 in every state other than MEMWR.
REQ-028: Latency in cycles: LW 5; SW, SB, RTYPE and ADDI 4; BEQ, BLE and J 3.
REQ-029: At most one of memwrite, regwrite and irwrite SHALL be high in any cycle.

Reset
REQ-030: reset high at a clock edge SHALL force state to FETCH at that edge, regardless of current state, including mid-instruction.
REQ-031: During a reset cycle, memwrite, regwrite, irwrite and pcen SHALL be 0. All other outputs take their FETCH values.
REQ-032: The first cycle after reset deasserts SHALL be a normal FETCH with pcen=1 and irwrite=1.

Structure
REQ-033: A shared package SHALL hold the opcode constants, the state enum (4-bit) and the alucontrol constants.
REQ-034: The R-type funct-to-alucontrol mapping SHALL come from an instantiated aludec sub-module (aluop 10). The FSM drives aluop 00 for add and 01 for subtract.

Verification
REQ-035: LW (op=100011) from reset release -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; back to FETCH in cycle 6.
REQ-036: SB (op=101000) -> memwrite=1 and memwidth=1 in cycle 4 only. SW (op=101011) -> memwidth=0 throughout.
REQ-037: BLE with {zero,sign} = 00, 01, 10 -> pcen = 0, 1, 1 in BLEEX. BEQ with zero=0, sign=1 -> pcen=0.
REQ-038: R-type add (funct=100000) -> alucontrol=010 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB.
REQ-039: Reset asserted in MEMWR -> no memwrite that cycle; state=FETCH next cycle. Undefined op=111111 -> FETCH, DECODE, FETCH with all enables 0 in DECODE.
